multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the existing datapath (PC counter, instruction ROM, register file, ALU, data RAM) over several cycles per instruction.
- Replaces the single-cycle main control unit and adds a memory-ready handshake, timeout detection, halt on illegal opcode, and a retired-instruction counter.
- Sits beside the ALU control unit and drives all datapath enables and select lines.

---
 rtl/multicycle_pkg.sv | 62 ++++++
 rtl/multicycle_sequencer_mem_wait_timer.sv | 34 +++
 rtl/multicycle_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
//   - FSM state encodings (IDLE=0 ... WB=5, HALT=7)
//   - opcode constants, ALUcontrol codes, err codes
//   - instruction class enum and the opcode decoder
// Optional feature macro: MULTICYCLE_SEQ_BEQ_EN (makes opcode 0x04 / beq legal).
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_ADDI  = 3'd1,
        CLS_LW    = 3'd2,
        CLS_SW    = 3'd3,
        CLS_BEQ   = 3'd4
    } cls_t;

    typedef struct packed {
        logic legal;
        cls_t cls;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d.legal = 1'b1;
        d.cls   = CLS_RTYPE;
        case (op)
            OP_RTYPE: d.cls = CLS_RTYPE;
            OP_ADDI:  d.cls = CLS_ADDI;
            OP_LW:    d.cls = CLS_LW;
            OP_SW:    d.cls = CLS_SW;
`ifdef MULTICYCLE_SEQ_BEQ_EN
            OP_BEQ:   d.cls = CLS_BEQ;
`endif
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts consecutive MEM cycles without mem_ready and flags a timeout.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - clear the count (asserted whenever the FSM is not in MEM)
//   en          - a MEM cycle with mem_ready low
//   timeout     - this waiting cycle is the MEM_TIMEOUT-th one in a row
// MEM_TIMEOUT = 0 disables the timeout entirely.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wait_cnt <= '0;
        end else if (en) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // The count holds the waits already seen; this cycle's wait is the one
    // that brings the total to MEM_TIMEOUT.
    assign timeout = (MEM_TIMEOUT != 0) && en && (wait_cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM sequencing PC, instruction ROM, register file,
// ALU and data RAM. Adds a memory-ready handshake with timeout, halt on
// illegal opcode, and a retired-instruction counter.
// Ports:
//   clk, reset, run, opcode[5:0], zf, mem_ready            - inputs
//   ir_we, CP, RegWrite, RegDest, ALUsrc, ALUcontrol[1:0],
//   ReadEn, WriteEn, MemtoReg, pc_src                      - datapath controls
//   busy, halted, err[1:0], retire_cnt[CNT_W-1:0], state_o - status
// Optional feature macro: MULTICYCLE_SEQ_BEQ_EN (beq retires in EXEC,
// pc_src = zf); when undefined beq is illegal and pc_src is tied to 0.
module multicycle_sequencer
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             zf,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             CP,
    output logic             RegWrite,
    output logic             RegDest,
    output logic             ALUsrc,
    output logic [1:0]       ALUcontrol,
    output logic             ReadEn,
    output logic             WriteEn,
    output logic             MemtoReg,
    output logic             pc_src,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [2:0]       state_o
);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] retire_cnt_q;
    dec_t             dec;
    logic             retire;
    logic             ir_we_c, reg_write_c, read_en_c, write_en_c;
    logic             mem_timeout;

    assign dec = decode_op(opcode);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != ST_MEM),
        .en      ((state_q == ST_MEM) && !mem_ready),
        .timeout (mem_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cls_q        <= CLS_RTYPE;
            err_q        <= ERR_NONE;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            err_q        <= err_d;
            retire_cnt_q <= retire_cnt_q + CNT_W'(retire);
        end
    end

`ifdef MULTICYCLE_SEQ_BEQ_EN
    logic pc_src_c;
`endif

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        err_d       = err_q;
        retire      = 1'b0;
        ir_we_c     = 1'b0;
        reg_write_c = 1'b0;
        read_en_c   = 1'b0;
        write_en_c  = 1'b0;
        RegDest     = 1'b0;
        MemtoReg    = 1'b0;
        ALUsrc      = 1'b0;
        ALUcontrol  = ALU_ADD;
`ifdef MULTICYCLE_SEQ_BEQ_EN
        pc_src_c    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_we_c = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec.legal) begin
                    cls_d   = dec.cls;
                    state_d = ST_EXEC;
                end else begin
                    err_d   = ERR_ILLEGAL;
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_RTYPE: begin
                        ALUcontrol = ALU_FUNCT;
                        state_d    = ST_WB;
                    end
                    CLS_ADDI: begin
                        ALUsrc  = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        ALUsrc  = 1'b1;
                        state_d = ST_MEM;
                    end
`ifdef MULTICYCLE_SEQ_BEQ_EN
                    CLS_BEQ: begin
                        ALUcontrol = ALU_SUB;
                        pc_src_c   = zf;
                        retire     = 1'b1;
                        state_d    = run ? ST_FETCH : ST_IDLE;
                    end
`endif
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                ALUsrc     = 1'b1;
                read_en_c  = (cls_q == CLS_LW);
                write_en_c = (cls_q == CLS_SW);
                if (mem_ready) begin
                    if (cls_q == CLS_LW) begin
                        state_d = ST_WB;
                    end else begin
                        // sw completes here: no write-back stage.
                        retire  = 1'b1;
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end
                end else if (mem_timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                RegDest     = (cls_q == CLS_RTYPE);
                MemtoReg    = (cls_q == CLS_LW);
                ALUsrc      = (cls_q != CLS_RTYPE);
                ALUcontrol  = (cls_q == CLS_RTYPE) ? ALU_FUNCT : ALU_ADD;
                state_d     = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are masked during reset so a write caught mid-MEM never lands.
    assign ir_we    = ir_we_c     & ~reset;
    assign CP       = retire      & ~reset;
    assign RegWrite = reg_write_c & ~reset;
    assign ReadEn   = read_en_c   & ~reset;
    assign WriteEn  = write_en_c  & ~reset;

`ifdef MULTICYCLE_SEQ_BEQ_EN
    assign pc_src = pc_src_c & ~reset;
`else
    logic unused_zf;
    assign unused_zf = zf;
    assign pc_src    = 1'b0;
`endif

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted     = (state_q == ST_HALT);
    assign err        = err_q;
    assign retire_cnt = retire_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MEM_TIMEOUT=4, CNT_W=4).
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       reset, run, zf, mem_ready;
    logic [5:0] opcode;
    logic       ir_we, CP, RegWrite, RegDest, ALUsrc, ReadEn, WriteEn, MemtoReg, pc_src;
    logic       busy, halted;
    logic [1:0] ALUcontrol, err;
    logic [3:0] retire_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zf(zf),
        .mem_ready(mem_ready), .ir_we(ir_we), .CP(CP), .RegWrite(RegWrite),
        .RegDest(RegDest), .ALUsrc(ALUsrc), .ALUcontrol(ALUcontrol),
        .ReadEn(ReadEn), .WriteEn(WriteEn), .MemtoReg(MemtoReg), .pc_src(pc_src),
        .busy(busy), .halted(halted), .err(err), .retire_cnt(retire_cnt),
        .state_o(state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    // Runs one instruction from IDLE or from a retirement cycle with run=1.
    // Stops at the retirement cycle (CP high) or on entering HALT.
    // snap = {pc_src, ALUcontrol, ALUsrc, WriteEn, RegWrite, MemtoReg, RegDest} at CP.
    task automatic run_instr(input logic [5:0] op, input int waits, input logic run_after,
                             output int cyc, output int rd_n, output int wr_n,
                             output int rw_n, output logic [7:0] snap);
        int  mem_n;
        logic done;
        cyc = 0; rd_n = 0; wr_n = 0; rw_n = 0; snap = '0; mem_n = 0; done = 1'b0;
        opcode = op;
        run    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            cyc++;
            if (state_o == 3'd4) begin
                mem_ready = (mem_n == waits);
                mem_n++;
            end
            #1;
            if (ReadEn)   rd_n++;
            if (WriteEn)  wr_n++;
            if (RegWrite) rw_n++;
            if (CP) begin
                snap = {pc_src, ALUcontrol, ALUsrc, WriteEn, RegWrite, MemtoReg, RegDest};
                run  = run_after;
                done = 1'b1;
                break;
            end
            if (halted) begin
                done = 1'b1;
                break;
            end
        end
        chk("instr_bounded", 32'(done), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    int cyc, rd_n, wr_n, rw_n;
    logic [7:0] snap;

    initial begin
        reset = 1'b1; run = 1'b0; zf = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
        tick();
        tick();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt", 32'(retire_cnt), 0);
        chk("rst_strobes", 32'({ir_we, CP, RegWrite, ReadEn, WriteEn}), 0);
        reset = 1'b0;

        // R-type walked cycle by cycle
        run = 1'b1; opcode = 6'h00;
        tick();
        chk("r_fetch_state", 32'(state_o), 1);
        chk("r_fetch_irwe", 32'(ir_we), 1);
        tick();
        chk("r_decode_state", 32'(state_o), 2);
        chk("r_decode_irwe", 32'(ir_we), 0);
        tick();
        chk("r_exec_alu", 32'({ALUcontrol, ALUsrc}), 32'({2'b10, 1'b0}));
        tick();
        chk("r_wb_ctl", 32'({RegWrite, RegDest, CP, MemtoReg}), 32'(4'b1110));
        run = 1'b0;
        tick();
        exp_cnt++;
        chk("r_idle", 32'(state_o), 0);
        chk("r_cnt", 32'(retire_cnt), 32'(exp_cnt));

        // lw with three wait cycles
        run_instr(6'h23, 3, 1'b0, cyc, rd_n, wr_n, rw_n, snap);
        chk("lw_cycles", 32'(cyc), 8);
        chk("lw_readen", 32'(rd_n), 4);
        chk("lw_wb", 32'(snap), 32'({1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}));
        tick();
        exp_cnt++;
        chk("lw_cnt", 32'(retire_cnt), 32'(exp_cnt));

        // sw ready on the first MEM cycle
        run_instr(6'h2B, 0, 1'b0, cyc, rd_n, wr_n, rw_n, snap);
        chk("sw_cycles", 32'(cyc), 4);
        chk("sw_writeen", 32'(wr_n), 1);
        chk("sw_regwrite", 32'(rw_n), 0);
        chk("sw_cp", 32'(snap), 32'({1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        tick();
        exp_cnt++;
        chk("sw_cnt", 32'(retire_cnt), 32'(exp_cnt));
        chk("sw_idle", 32'(state_o), 0);

        // addi then R-type back to back
        run_instr(6'h08, 0, 1'b1, cyc, rd_n, wr_n, rw_n, snap);
        exp_cnt++;
        chk("addi_cycles", 32'(cyc), 4);
        chk("addi_wb", 32'(snap), 32'({1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
        run_instr(6'h00, 0, 1'b0, cyc, rd_n, wr_n, rw_n, snap);
        exp_cnt++;
        chk("b2b_cycles", 32'(cyc), 4);
        chk("b2b_wb", 32'(snap), 32'({1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}));
        tick();
        chk("b2b_cnt", 32'(retire_cnt), 32'(exp_cnt));

        // run dropped during EXEC: instruction still retires, then IDLE
        run = 1'b1; opcode = 6'h00;
        tick(); tick(); tick();
        chk("drop_exec", 32'(state_o), 3);
        run = 1'b0;
        tick();
        chk("drop_wb_cp", 32'(CP), 1);
        tick();
        exp_cnt++;
        chk("drop_idle", 32'(state_o), 0);
        chk("drop_cnt", 32'(retire_cnt), 32'(exp_cnt));
        tick();
        chk("drop_stay_idle", 32'(state_o), 0);

        // beq
        zf = 1'b1;
        run_instr(6'h04, 0, 1'b0, cyc, rd_n, wr_n, rw_n, snap);
`ifdef MULTICYCLE_SEQ_BEQ_EN
        chk("beq_cycles", 32'(cyc), 3);
        chk("beq_exec", 32'(snap), 32'({1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        tick();
        exp_cnt++;
        chk("beq_cnt", 32'(retire_cnt), 32'(exp_cnt));
`else
        chk("beq_illegal_cycles", 32'(cyc), 3);
        chk("beq_illegal_err", 32'({halted, err}), 32'({1'b1, 2'b01}));
        chk("beq_pc_src", 32'(pc_src), 0);
        do_reset();
`endif
        zf = 1'b0;

        // illegal opcode halts and ignores run
        run_instr(6'h3F, 0, 1'b0, cyc, rd_n, wr_n, rw_n, snap);
        chk("ill_cycles", 32'(cyc), 3);
        chk("ill_status", 32'({halted, busy, err}), 32'({1'b1, 1'b0, 2'b01}));
        chk("ill_regwrite", 32'(rw_n), 0);
        run = 1'b0; tick();
        run = 1'b1; tick();
        run = 1'b0; tick();
        chk("ill_stuck", 32'({state_o, err}), 32'({3'd7, 2'b01}));
        chk("ill_enables", 32'({ir_we, CP, RegWrite, ReadEn, WriteEn}), 0);
        do_reset();
        chk("ill_rst_state", 32'(state_o), 0);
        chk("ill_rst_err", 32'(err), 0);
        chk("ill_rst_cnt", 32'(retire_cnt), 0);

        // lw with mem_ready stuck low times out after 4 MEM cycles
        run_instr(6'h23, 99, 1'b0, cyc, rd_n, wr_n, rw_n, snap);
        chk("tmo_cycles", 32'(cyc), 8);
        chk("tmo_readen", 32'(rd_n), 4);
        chk("tmo_status", 32'({state_o, err}), 32'({3'd7, 2'b10}));
        do_reset();

        // reset asserted mid-MEM of an sw: no write, counter cleared
        run_instr(6'h00, 0, 1'b0, cyc, rd_n, wr_n, rw_n, snap);
        tick();
        chk("pre_cnt", 32'(retire_cnt), 1);
        run = 1'b1; opcode = 6'h2B;
        tick(); tick(); tick(); tick();
        chk("rm_mem", 32'({state_o, WriteEn}), 32'({3'd4, 1'b1}));
        tick();
        reset = 1'b1;
        #1;
        chk("rm_write_masked", 32'({WriteEn, CP}), 0);
        tick();
        reset = 1'b0; run = 1'b0;
        chk("rm_idle", 32'(state_o), 0);
        chk("rm_cnt", 32'(retire_cnt), 0);
        chk("rm_writeen", 32'(WriteEn), 0);

        // retire_cnt wraps at 2^CNT_W
        for (int k = 0; k < 16; k++) begin
            run_instr(6'h00, 0, (k < 15), cyc, rd_n, wr_n, rw_n, snap);
        end
        chk("wrap_pre", 32'(retire_cnt), 15);
        tick();
        chk("wrap_zero", 32'(retire_cnt), 0);
        chk("wrap_idle", 32'(state_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
